// File: rtl/light_pkg.sv
// ---------------------------------------------------------------------------
// light_pkg
// Shared definitions for the traffic-light request monitor.
//   - Phase encoding (PH_*) as observed on the controller's light outputs.
//   - Request FSM state encoding (RQ_*).
//   - code_to_phase(): decodes a {green,yellow,red} triple into a phase plus
//     a legal bit (legal only when exactly one light is on).
//   - phase_successor(): the only legal follow-on phase of a lit phase.
// ---------------------------------------------------------------------------
package light_pkg;

  localparam logic [1:0] PH_UNK    = 2'd0;
  localparam logic [1:0] PH_GREEN  = 2'd1;
  localparam logic [1:0] PH_YELLOW = 2'd2;
  localparam logic [1:0] PH_RED    = 2'd3;

  localparam logic [0:0] RQ_IDLE = 1'b0;
  localparam logic [0:0] RQ_PEND = 1'b1;

  typedef struct packed {
    logic       legal;
    logic [1:0] phase;
  } phase_code_t;

  function automatic phase_code_t code_to_phase(input logic g, input logic y, input logic r);
    phase_code_t pc;
    pc.legal = 1'b1;
    pc.phase = PH_UNK;
    case ({g, y, r})
      3'b100:  pc.phase = PH_GREEN;
      3'b010:  pc.phase = PH_YELLOW;
      3'b001:  pc.phase = PH_RED;
      default: pc.legal = 1'b0;
    endcase
    return pc;
  endfunction

  function automatic logic [1:0] phase_successor(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_GREEN:  nxt = PH_YELLOW;
      PH_YELLOW: nxt = PH_RED;
      PH_RED:    nxt = PH_GREEN;
      default:   nxt = PH_UNK;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// CNT_W-wide up counter that loads 1, increments when enabled and sticks at
// its all-ones value instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset (count -> 0)
//   load  - load the value 1 (has priority over en)
//   en    - increment by one unless already saturated
//   count - current counter value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CNT_ONE;
    end else if (en && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + CNT_ONE;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/light_req_monitor.sv
// ---------------------------------------------------------------------------
// light_req_monitor
// Client-side companion of the traffic-light controller. Turns a one-cycle
// request pulse into a level request for the controller, watches the
// controller's lights, checks the phase order GREEN->YELLOW->RED->GREEN,
// reports how long each phase lasted and flags requests that wait too long.
//
// Build option: define LIGHT_REQ_SYNC_EN to pass the three light inputs
// through 2-flop synchronizers (adds 2 cycles of latency; the all-off reset
// value of the synchronizers is not treated as an error). Without it the
// lights must come from the same clock domain.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   req_pulse  - one-cycle request from a button/sensor
//   clr        - synchronous clear of sticky err/timeout (a new event wins)
//   green, yellow, red - controller light outputs
//   req        - level request to the controller
//   phase      - observed phase: 0=UNK 1=GREEN 2=YELLOW 3=RED
//   last_dwell - cycles spent in the most recently completed phase
//   dwell_vld  - one-cycle pulse when last_dwell updates
//   err        - sticky illegal-code / illegal-order flag
//   timeout    - sticky request-timeout flag
// ---------------------------------------------------------------------------
module light_req_monitor
  import light_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int REQ_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_pulse,
  input  logic             clr,
  input  logic             green,
  input  logic             yellow,
  input  logic             red,
  output logic             req,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] last_dwell,
  output logic             dwell_vld,
  output logic             err,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(REQ_TIMEOUT);

  // -------------------------------------------------------------------------
  // Light sampling
  // -------------------------------------------------------------------------
  logic [2:0] lights_s;      // {green, yellow, red} as seen by the phase FSM
  logic       startup_mask;  // suppress the synchronizer's reset value

`ifdef LIGHT_REQ_SYNC_EN
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;
  logic [1:0] startup_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg   <= 3'b000;
      sync2_reg   <= 3'b000;
      startup_reg <= 2'd0;
    end else begin
      sync1_reg <= {green, yellow, red};
      sync2_reg <= sync1_reg;
      if (startup_reg != 2'd2) begin
        startup_reg <= startup_reg + 2'd1;
      end
    end
  end

  assign lights_s = sync2_reg;
  // For the first two edges after reset the second stage still holds its
  // reset value rather than a real light code.
  assign startup_mask = (startup_reg != 2'd2) && (sync2_reg == 3'b000);
`else
  assign lights_s     = {green, yellow, red};
  assign startup_mask = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Phase FSM
  // -------------------------------------------------------------------------
  logic [1:0]       phase_reg;
  logic [1:0]       phase_next;
  phase_code_t      pc;
  logic             err_event;
  logic             phase_change;
  logic             dwell_report;
  logic             green_entry;
  logic             dwell_load;
  logic             dwell_en;
  logic [CNT_W-1:0] dwell_cnt;

  always_comb begin
    pc         = code_to_phase(lights_s[2], lights_s[1], lights_s[0]);
    phase_next = phase_reg;
    err_event  = 1'b0;
    if (!pc.legal) begin
      if (!startup_mask) begin
        err_event  = 1'b1;
        phase_next = PH_UNK;
      end
    end else if (phase_reg == PH_UNK) begin
      phase_next = pc.phase;
    end else if (pc.phase != phase_reg) begin
      // Out-of-order moves are still followed so the monitor re-locks on
      // the controller immediately; only the flag records the violation.
      phase_next = pc.phase;
      if (pc.phase != phase_successor(phase_reg)) begin
        err_event = 1'b1;
      end
    end
  end

  assign phase_change = (phase_next != phase_reg);
  assign dwell_report = phase_change && (phase_reg != PH_UNK);
  assign green_entry  = phase_change && (phase_next == PH_GREEN);
  assign dwell_load   = phase_change && (phase_next != PH_UNK);
  assign dwell_en     = !phase_change && (phase_reg != PH_UNK);

  sat_counter #(.CNT_W(CNT_W)) u_dwell_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (dwell_load),
    .en    (dwell_en),
    .count (dwell_cnt)
  );

  logic [CNT_W-1:0] last_dwell_reg;
  logic             dwell_vld_reg;
  logic             err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_reg      <= PH_UNK;
      last_dwell_reg <= '0;
      dwell_vld_reg  <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      phase_reg     <= phase_next;
      dwell_vld_reg <= dwell_report;
      if (dwell_report) begin
        last_dwell_reg <= dwell_cnt;
      end
      if (err_event) begin
        err_reg <= 1'b1;
      end else if (clr) begin
        err_reg <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Request FSM
  // -------------------------------------------------------------------------
  logic [0:0]       rq_state_reg;
  logic [0:0]       rq_state_next;
  logic             wait_load;
  logic             wait_en;
  logic             timeout_event;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_reg;

  always_comb begin
    rq_state_next = rq_state_reg;
    wait_load     = 1'b0;
    case (rq_state_reg)
      RQ_IDLE: begin
        // A pulse coinciding with green entry is already satisfied.
        if (req_pulse && !green_entry) begin
          rq_state_next = RQ_PEND;
          wait_load     = 1'b1;
        end
      end
      RQ_PEND: begin
        if (green_entry) begin
          rq_state_next = RQ_IDLE;
        end
      end
      default: rq_state_next = RQ_IDLE;
    endcase
  end

  assign wait_en       = (rq_state_reg == RQ_PEND);
  // The wait counter keeps running past the limit, so this fires once.
  assign timeout_event = (rq_state_reg == RQ_PEND) && (wait_cnt == TIMEOUT_CNT);

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (wait_load),
    .en    (wait_en),
    .count (wait_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rq_state_reg <= RQ_IDLE;
      timeout_reg  <= 1'b0;
    end else begin
      rq_state_reg <= rq_state_next;
      if (timeout_event) begin
        timeout_reg <= 1'b1;
      end else if (clr) begin
        timeout_reg <= 1'b0;
      end
    end
  end

  assign req        = (rq_state_reg == RQ_PEND);
  assign phase      = phase_reg;
  assign last_dwell = last_dwell_reg;
  assign dwell_vld  = dwell_vld_reg;
  assign err        = err_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_light_req_monitor.sv
// ---------------------------------------------------------------------------
// tb_light_req_monitor
// Directed bench for light_req_monitor (default build, REQ_TIMEOUT=10).
// Expected dwell values are queued as the light sequence is driven and are
// popped by a monitor whenever dwell_vld pulses.
// ---------------------------------------------------------------------------
module tb_light_req_monitor;

  localparam int CNT_W = 16;
  localparam int REQ_TIMEOUT = 10;

  localparam logic [2:0] L_G   = 3'b100;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_R   = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;
  localparam logic [2:0] L_GY  = 3'b110;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_pulse;
  logic             clr;
  logic [2:0]       lights;
  logic             req;
  logic [1:0]       phase;
  logic [CNT_W-1:0] last_dwell;
  logic             dwell_vld;
  logic             err;
  logic             timeout;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_dwell_seen = 0;
  int n_dwell_pushed = 0;
  int dwell_q[$];

  light_req_monitor #(
    .CNT_W       (CNT_W),
    .REQ_TIMEOUT (REQ_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_pulse  (req_pulse),
    .clr        (clr),
    .green      (lights[2]),
    .yellow     (lights[1]),
    .red        (lights[0]),
    .req        (req),
    .phase      (phase),
    .last_dwell (last_dwell),
    .dwell_vld  (dwell_vld),
    .err        (err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
    $display("  check %-14s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  task automatic push_dwell(input int d);
    dwell_q.push_back(d);
    n_dwell_pushed++;
  endtask

  // Drive a light code for n rising edges; outputs are then sampled 1 time
  // unit after the last edge.
  task automatic hold(input logic [2:0] code, input int n);
    lights = code;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every dwell_vld pulse must match the oldest expected dwell.
  always @(negedge clk) begin
    if (rst === 1'b1 && dwell_vld === 1'b1) begin
      n_dwell_seen++;
      if (dwell_q.size() == 0) begin
        check("dwell_extra", 32'(last_dwell), 32'hFFFF_FFFF);
      end else begin
        check("dwell_val", 32'(last_dwell), 32'(dwell_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b0; req_pulse = 1'b0; clr = 1'b0; lights = L_OFF;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(req), 0);
    check("rst_phase", 32'(phase), 0);
    check("rst_dwell", 32'(last_dwell), 0);
    check("rst_vld", 32'(dwell_vld), 0);
    check("rst_err", 32'(err), 0);
    check("rst_timeout", 32'(timeout), 0);

    // Release with green: UNK -> GREEN is not an error and reports no dwell
    rst = 1'b1;
    hold(L_G, 1);
    check("start_phase", 32'(phase), 1);
    check("start_err", 32'(err), 0);

    // G x5, Y x3, R x4, G
    hold(L_G, 4);
    push_dwell(5);
    hold(L_Y, 1);
    check("seq_phase_y", 32'(phase), 2);
    check("seq_vld_y", 32'(dwell_vld), 1);
    hold(L_Y, 2);
    push_dwell(3);
    hold(L_R, 4);
    push_dwell(4);
    hold(L_G, 1);
    check("seq_phase_g", 32'(phase), 1);
    check("seq_err", 32'(err), 0);

    // Illegal order GREEN -> RED: flagged, followed, dwell still reported
    push_dwell(1);
    hold(L_R, 1);
    check("ord_err", 32'(err), 1);
    check("ord_phase", 32'(phase), 3);
    clr = 1'b1;
    hold(L_R, 1);
    clr = 1'b0;
    check("clr_err", 32'(err), 0);

    // Illegal code 110 -> UNK, RED dwell of 2 reported
    push_dwell(2);
    hold(L_GY, 1);
    check("code_err", 32'(err), 1);
    check("code_phase", 32'(phase), 0);

    // clr together with a new illegal code: set wins
    clr = 1'b1;
    hold(L_OFF, 1);
    check("setwin_err", 32'(err), 1);
    check("setwin_phase", 32'(phase), 0);
    hold(L_R, 1);
    clr = 1'b0;
    check("relock_err", 32'(err), 0);
    check("relock_phase", 32'(phase), 3);

    // Request during RED, green appears 7 cycles after the pulse
    req_pulse = 1'b1;
    hold(L_R, 1);
    req_pulse = 1'b0;
    check("req_rise", 32'(req), 1);
    hold(L_R, 6);
    check("req_wait", 32'(req), 1);
    push_dwell(8);
    hold(L_G, 1);
    check("req_served", 32'(req), 0);
    check("req_phase", 32'(phase), 1);
    check("req_no_to", 32'(timeout), 0);

    // Request while already GREEN: waits for the next green entry; times out
    req_pulse = 1'b1;
    hold(L_G, 1);
    req_pulse = 1'b0;
    check("reqg_rise", 32'(req), 1);
    push_dwell(2);
    hold(L_Y, 1);
    check("reqg_y", 32'(req), 1);
    push_dwell(1);
    hold(L_R, 7);
    check("to_early", 32'(timeout), 0);
    hold(L_R, 1);
    check("to_edge_m1", 32'(timeout), 0);
    hold(L_R, 1);
    check("to_set", 32'(timeout), 1);
    check("to_req", 32'(req), 1);
    hold(L_R, 11);
    check("to_hold", 32'(timeout), 1);
    push_dwell(20);
    hold(L_G, 1);
    check("to_served", 32'(req), 0);
    check("to_sticky", 32'(timeout), 1);
    clr = 1'b1;
    hold(L_G, 1);
    clr = 1'b0;
    check("to_clr", 32'(timeout), 0);

    // Pulse in the same cycle as green entry: serviced, stays idle
    push_dwell(2);
    hold(L_Y, 1);
    push_dwell(1);
    hold(L_R, 1);
    push_dwell(1);
    req_pulse = 1'b1;
    hold(L_G, 1);
    req_pulse = 1'b0;
    check("same_req", 32'(req), 0);
    hold(L_G, 1);
    check("same_req2", 32'(req), 0);

    // Reset mid-request: req drops without a clock edge, request is lost
    req_pulse = 1'b1;
    hold(L_G, 1);
    req_pulse = 1'b0;
    check("mid_req", 32'(req), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_req", 32'(req), 0);
    check("mid_rst_ph", 32'(phase), 0);
    hold(L_G, 2);
    rst = 1'b1;
    hold(L_G, 3);
    check("post_req", 32'(req), 0);
    check("post_phase", 32'(phase), 1);
    check("post_err", 32'(err), 0);

    // Every queued dwell must have been reported
    @(negedge clk);
    #1;
    check("dwell_left", 32'(dwell_q.size()), 0);
    check("dwell_count", 32'(n_dwell_seen), 32'(n_dwell_pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/light_req_monitor.md
Name: light_req_monitor

Overview:
- Client-side counterpart of the traffic-light controller `fsm`.
- Drives the controller's request input `a` from a debounced-free request pulse, and observes its `green`/`yellow`/`red` outputs.
- Checks the observed phase sequence for legality, measures the dwell time of each phase, and flags unserviced requests.
- Sits beside `fsm` in the top level; its `req` output connects to `fsm.a`.

Parameters:
- CNT_W, 16: width of the dwell and wait counters.
- REQ_TIMEOUT, 1000: cycles a pending request may wait for green before `timeout` asserts; must be < 2^CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_pulse  input  1  one-cycle request from a button or sensor.
- clr  input  1  synchronous clear of sticky flags (`err`, `timeout`).
- green  input  1  controller green output.
- yellow  input  1  controller yellow output.
- red  input  1  controller red output.
- req  output  1  level request to the controller (drives `a`).
- phase  output  2  current observed phase: 0=UNK, 1=GREEN, 2=YELLOW, 3=RED.
- last_dwell  output  CNT_W  cycles spent in the most recently completed phase.
- dwell_vld  output  1  one-cycle pulse when `last_dwell` updates.
- err  output  1  sticky illegal-sequence / illegal-code flag.
- timeout  output  1  sticky request-timeout flag.

Behaviour:
- Reset (`rst`=0, async): all outputs 0; phase=UNK; counters 0; request state IDLE.
- Light code: the input triple {green,yellow,red} is legal only if exactly one bit is set.
- Phase FSM, evaluated every cycle on the sampled light code:
  - UNK: on any legal code, go to that phase; no dwell is reported and the move is not an error.
  - GREEN: stays in GREEN on green; on yellow goes to YELLOW; red is an illegal order.
  - YELLOW: stays in YELLOW on yellow; on red goes to RED; green is an illegal order.
  - RED: stays in RED on red; on green goes to GREEN; yellow is an illegal order.
  - Any state, illegal code (0 or ≥2 bits set): `err`<=1 and phase<=UNK.
  - Any state, illegal order: `err`<=1 and phase<=the new legal phase. Dwell is still reported.
- Dwell counter:
  - Resets to 1 on entry to a phase.
  - Increments each cycle the phase is held.
  - Saturates at 2^CNT_W-1; it never wraps.
  - On a phase change out of GREEN/YELLOW/RED: `last_dwell`<=counter and `dwell_vld`=1 for one cycle, one cycle after the light change is sampled.
- Request FSM:
  - IDLE: `req_pulse` → PEND, `req`<=1 (registered, so `req` rises one cycle after the pulse).
  - PEND: the wait counter increments each cycle.
    - On an observed transition into GREEN → IDLE, `req`<=0.
    - When wait == REQ_TIMEOUT: `timeout`<=1 and the state stays PEND.
  - `req_pulse` while in PEND is ignored; there is no queueing.
  - `req_pulse` in the same cycle as entry to GREEN is serviced, then dropped: the result is IDLE.
  - If the phase is already GREEN when the request arrives, it is not serviced until the next RED→GREEN transition.
- Flags:
  - `err` and `timeout` stay set until `clr`=1 or reset.
  - `clr` in the same cycle as a new event: set wins.
- Reset mid-request: `req` drops immediately (async); the request is lost.

Optional Feature:
- Macro LIGHT_REQ_SYNC_EN.
- Defined: `green`, `yellow` and `red` each pass through a 2-flop synchronizer, reset to 0, before the phase FSM. This adds 2 cycles to every phase-related latency. The reset value 000 is masked as UNK for the first 2 cycles after reset and is not flagged as an error.
- Undefined: the lights are sampled directly. Same-clock connection to `fsm` is required.

Decomposition:
- Shared package `light_pkg`:
  - Phase encoding localparams PH_UNK=2'd0, PH_GREEN=2'd1, PH_YELLOW=2'd2, PH_RED=2'd3.
  - Request state encoding RQ_IDLE, RQ_PEND.
  - Function `code_to_phase(g,y,r)` returning the phase plus a legal bit.
- Sub-module `sat_counter`: CNT_W-wide saturating counter with load-1 and enable, instantiated twice (dwell and wait).

Test Plan:
- Reset with lights=000 → all outputs 0 and phase=0. After rst=1 with lights=100 → phase=1 next cycle, err=0.
- Drive G×5, Y×3, R×4, G → `dwell_vld` pulses with `last_dwell` = 5, 3, 4 in order; err=0.
- Drive G then R directly → err=1, phase=3. Pulse clr → err=0. Drive 110 → err=1, phase=0.
- `req_pulse` during R, G appears 7 cycles later → req high from the cycle after the pulse, low one cycle after green is sampled; timeout=0.
- REQ_TIMEOUT=10 with R held for 20 cycles after `req_pulse` → timeout=1 at wait=10 with req still 1. Then G → req=0 and timeout stays 1 until clr.
- Assert rst=0 mid-PEND → req=0 immediately. After release, req stays 0 until a new `req_pulse`.
